// File: rtl/mem_responder.sv
// Word-wide main-memory responder: one request at a time, fixed LATENCY from accept to a one-cycle memdone.
// Writes commit byte-masked on the edge entering DONE; reads drive memdata only during the DONE cycle.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADRBITS = 12,
  parameter int LATENCY = 2
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [26:0] memadr,
  inout  wire  [31:0] memdata,
  input  logic [3:0]  membyteen,
  input  logic        memrwb,
  input  logic        memen,
  output logic        memdone,
  output logic        adrerr,
  output logic        busy
);

  localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam int DEPTH = 1 << ADRBITS;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;
  logic          r_busy;
  logic          r_rd_drv;
  logic [31:0]   r_rdata;
  logic [26:0]   r_adr;
  logic          r_rwb;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_inrange;
  logic [31:0]   r_mem [0:DEPTH-1];

  logic [26:0]        w_adr;
  logic               w_rwb;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic               w_inrange;
  logic [ADRBITS-1:0] w_idx;
  logic               w_enter_done;
  logic               w_wr_en;

  // With LATENCY=1 the DONE-entry edge is the accept edge, so the live bus is used instead of the capture.
  assign w_adr     = (r_state == S_IDLE) ? memadr    : r_adr;
  assign w_rwb     = (r_state == S_IDLE) ? memrwb    : r_rwb;
  assign w_be      = (r_state == S_IDLE) ? membyteen : r_be;
  assign w_wdata   = (r_state == S_IDLE) ? memdata   : r_wdata;
  assign w_inrange = (r_state == S_IDLE) ? (memadr[26:ADRBITS] == '0) : r_inrange;
  assign w_idx     = w_adr[ADRBITS-1:0];

  assign w_enter_done = !reset && memen &&
                        (((r_state == S_IDLE) && (LATENCY == 1)) ||
                         ((r_state == S_BUSY) && (r_cnt == '0)));
  assign w_wr_en = w_enter_done && !w_rwb && w_inrange;

  always_ff @(posedge ph1) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_drv <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_enter_done) begin
        r_state  <= S_DONE;
        r_done   <= 1'b1;
        r_err    <= ~w_inrange;
        r_busy   <= 1'b1;
        r_rd_drv <= w_rwb;
        r_rdata  <= (w_rwb && w_inrange) ? r_mem[w_idx] : 32'h0000_0000;
      end
      case (r_state)
        S_IDLE: begin
          if (memen) begin
            r_adr     <= memadr;
            r_rwb     <= memrwb;
            r_be      <= membyteen;
            r_wdata   <= memdata;
            r_inrange <= (memadr[26:ADRBITS] == '0);
            if (LATENCY != 1) begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
              r_cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        S_BUSY: begin
          if (!memen) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_rd_drv <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign memdone = r_done;
  assign adrerr  = r_err;
  assign busy    = r_busy;
  assign memdata = r_rd_drv ? r_rdata : 32'bz;

endmodule

// File: tb/tb_mem_responder.sv
// Four responders at LATENCY 2/4/1/5 exercised one at a time; a per-cycle compare checks
// memdone/adrerr/busy/memdata against a request-level model of timing and memory contents.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int NI = 4;
  localparam int LAT [NI] = '{2, 4, 1, 5};

  logic ph1 = 1'b0;
  logic reset;
  int   cyc = 0;

  logic [26:0] adr  [NI];
  logic [3:0]  be   [NI];
  logic        rwb  [NI];
  logic        en   [NI];
  logic [31:0] tdat [NI];
  wire  [31:0] md_obs [NI];
  wire  [NI-1:0] done, err, bsy;

  // model of the request in flight, per instance
  int          m_lo [NI], m_hi [NI], m_done [NI];
  bit          m_rd [NI], m_err [NI], m_kn [NI], m_lv [NI];
  logic [31:0] m_rdat [NI], m_lit [NI];
  logic [31:0] mdl [NI][16];
  bit          known [NI][16];

  int n_chk = 0;
  int n_pass = 0;

  always #5 ph1 = ~ph1;
  always @(posedge ph1) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire [31:0] bus;
    assign bus = (cyc == m_done[g] && m_rd[g]) ? 32'bz : tdat[g];
    assign md_obs[g] = bus;
    mem_responder #(.ADRBITS(12), .LATENCY(LAT[g])) u_dut (
      .ph1(ph1), .reset(reset), .memadr(adr[g]), .memdata(bus),
      .membyteen(be[g]), .memrwb(rwb[g]), .memen(en[g]),
      .memdone(done[g]), .adrerr(err[g]), .busy(bsy[g])
    );
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d(L=%0d) cyc%0d: got %h expected %h", nm, i, LAT[i], cyc, act, exp);
  endtask

  always @(negedge ph1) begin
    if (cyc >= 1) begin
      for (int i = 0; i < NI; i++) begin
        bit ed;
        ed = (cyc == m_done[i]);
        chk("memdone", i, 32'(done[i]), 32'(ed));
        chk("adrerr", i, 32'(err[i]), 32'(ed && m_err[i]));
        chk("busy", i, 32'(bsy[i]), 32'(cyc >= m_lo[i] && cyc <= m_hi[i]));
        if (ed && m_rd[i]) begin
          if (m_kn[i]) chk("rdata", i, md_obs[i], m_rdat[i]);
          if (m_lv[i]) chk("pin", i, m_rdat[i], m_lit[i]);
        end else begin
          chk("bus_released", i, md_obs[i], tdat[i]);
        end
      end
    end
  end

  task automatic scramble(input int i);
    adr[i]  = 27'($urandom);
    rwb[i]  = 1'($urandom);
    be[i]   = 4'($urandom);
    tdat[i] = $urandom;
  endtask

  // mode 0: complete, 1: drop memen at edge E+k, 2: reset at edge E+k (E = accept edge)
  task automatic req(input int i, input logic [26:0] a, input logic r, input logic [3:0] b,
                     input logic [31:0] d, input int mode, input int k,
                     input bit lv, input logic [31:0] lval);
    int e, l, ix, n;
    bit inr;
    l   = LAT[i];
    e   = cyc + 1;
    inr = (a[26:12] == 15'd0);
    ix  = int'(a[3:0]);
    adr[i] = a; rwb[i] = r; be[i] = b; tdat[i] = d; en[i] = 1'b1;
    m_lv[i] = lv; m_lit[i] = lval;
    if (mode == 0) begin
      m_lo[i] = e; m_hi[i] = e + l - 1; m_done[i] = e + l - 1;
      m_rd[i] = r; m_err[i] = !inr;
      if (r) begin
        m_rdat[i] = inr ? mdl[i][ix] : 32'h0;
        m_kn[i]   = inr ? known[i][ix] : 1'b1;
      end else if (inr) begin
        for (int j = 0; j < 4; j++)
          if (b[j]) mdl[i][ix][8*j +: 8] = d[8*j +: 8];
        known[i][ix] = known[i][ix] || (b == 4'hF);
      end
      n = l - 1;
    end else begin
      m_lo[i] = e; m_hi[i] = e + k - 1; m_done[i] = -1;
      n = k - 1;
    end
    @(posedge ph1); #1; scramble(i);
    repeat (n) begin @(posedge ph1); #1; scramble(i); end
    if (mode == 2) begin
      reset = 1'b1;
      @(posedge ph1); #1;
      reset = 1'b0;
    end
    en[i] = 1'b0;
    @(posedge ph1); #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      adr[i] = '0; be[i] = '0; rwb[i] = 1'b0; en[i] = 1'b0; tdat[i] = $urandom;
      m_lo[i] = 1; m_hi[i] = 0; m_done[i] = -1;
      m_rd[i] = 0; m_err[i] = 0; m_kn[i] = 0; m_lv[i] = 0; m_rdat[i] = '0; m_lit[i] = '0;
      for (int j = 0; j < 16; j++) begin mdl[i][j] = '0; known[i][j] = 0; end
    end
    repeat (3) @(posedge ph1);
    #1 reset = 1'b0;
    @(posedge ph1); #1;

    // LATENCY=2: full, partial, empty byte-enable writes; range checks; reset mid-write
    req(0, 27'd5, 0, 4'hF, 32'hCAFEBABE, 0, 0, 0, 0);
    req(0, 27'd5, 1, 4'h0, 32'h0,        0, 0, 1, 32'hCAFEBABE);
    req(0, 27'd5, 0, 4'h3, 32'h11223344, 0, 0, 0, 0);
    req(0, 27'd5, 1, 4'hF, 32'h0,        0, 0, 1, 32'hCAFE3344);
    req(0, 27'd5, 0, 4'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    req(0, 27'd5, 1, 4'h0, 32'h0,        0, 0, 1, 32'hCAFE3344);
    req(0, 27'd0, 0, 4'hF, 32'hA5A50000, 0, 0, 0, 0);
    req(0, 27'h1000, 1, 4'hF, 32'h0,     0, 0, 1, 32'h00000000);
    req(0, 27'h1000, 0, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0);
    req(0, 27'd0, 1, 4'h0, 32'h0,        0, 0, 1, 32'hA5A50000);
    req(0, 27'd9, 0, 4'hF, 32'h99990000, 0, 0, 0, 0);
    req(0, 27'd9, 0, 4'hF, 32'h12121212, 2, 1, 0, 0);
    req(0, 27'd9, 1, 4'h0, 32'h0,        0, 0, 1, 32'h99990000);

    // LATENCY=4: abort after two cycles leaves memory untouched
    req(1, 27'd7, 0, 4'hF, 32'h0BADF00D, 0, 0, 0, 0);
    req(1, 27'd7, 0, 4'hF, 32'h12345678, 1, 2, 0, 0);
    req(1, 27'd7, 1, 4'h0, 32'h0,        0, 0, 1, 32'h0BADF00D);

    // LATENCY=1 and 5: back-to-back with a single idle cycle between requests
    for (int i = 2; i < NI; i++) begin
      req(i, 27'd3, 0, 4'hF, 32'h5A5A1234, 0, 0, 0, 0);
      req(i, 27'd3, 1, 4'h0, 32'h0,        0, 0, 1, 32'h5A5A1234);
      req(i, 27'h2003, 1, 4'hF, 32'h0,     0, 0, 1, 32'h00000000);
      req(i, 27'd3, 0, 4'h9, 32'h77665544, 0, 0, 0, 0);
      req(i, 27'd3, 1, 4'h0, 32'h0,        0, 0, 1, 32'h775A1244);
    end

    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 120; t++) begin
        logic [26:0] a;
        logic [3:0]  b;
        int mode, k, l;
        l = LAT[i];
        if ($urandom_range(0, 7) == 0)
          a = {15'($urandom_range(1, 32767)), 12'($urandom_range(0, 15))};
        else
          a = 27'($urandom_range(0, 15));
        b = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        mode = 0; k = 0;
        if (l > 1 && $urandom_range(0, 5) == 0) begin
          mode = ($urandom_range(0, 2) == 0) ? 2 : 1;
          k = $urandom_range(1, l - 1);
        end
        req(i, a, 1'($urandom), b, $urandom, mode, k, 0, 0);
        repeat ($urandom_range(0, 2)) @(posedge ph1);
        #1;
      end
    end

    repeat (3) @(posedge ph1);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
